pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall and multi-cycle sequencing controller for the six-stage integer pipeline (PC, IF, ID, EX, MEM, WB). It merges stall requests from ID, EX and MEM into one stall vector that freezes the pipeline registers. It sequences multi-cycle EX operations (multiply-accumulate, iterative divide) by holding the EX instruction for a requested number of cycles. It also handles flush from the exception path and keeps a free-running stall-cycle performance counter.

## Interface
- MC_W, 6, width of the multi-cycle length field (max 63 stall cycles)
- CNT_W, 32, width of the stall performance counter

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  ID hazard (load-use) stall request
- stallreq_mem  in  1  MEM wait (data memory not ready)
- ex_mc_start  in  1  EX issues a multi-cycle op this cycle
- ex_mc_cycles  in  MC_W  stall cycles N the op needs; sampled with ex_mc_start
- flush  in  1  exception/flush from MEM; cancels everything in flight
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage register
- ex_mc_busy  out  1  multi-cycle op is in progress (state BUSY)
- ex_mc_done  out  1  one-cycle pulse: EX result valid, EX advances at the end of this cycle
- stall_cycles  out  CNT_W  count of cycles with stall[0]=1

## Operation
- FSM states:
  - IDLE: ex_mc_start with N≥2 → BUSY, cnt←N-1. With N=1 → DONE. With N=0 the op is ignored (single-cycle, no stall).
  - BUSY: cnt←cnt-1 each cycle. When cnt==1 → DONE.
  - DONE: ex_mc_done=1, then → IDLE.
  - ex_mc_start is ignored in BUSY and DONE.
- EX stall request (ex_req) is 1 in:
  - IDLE when ex_mc_start && N≠0;
  - every BUSY cycle.
  - Not in DONE. Total stall cycles for an op = N, followed by one DONE cycle.
- stall vector is combinational, priority high to low:
  - rst or flush → 000000;
  - stallreq_mem → 011111;
  - ex_req → 001111;
  - stallreq_id → 000111;
  - else → 000000.
- Simultaneous requests resolve to the longest vector (highest listed); the lower requests stay pending implicitly, since their sources reassert them.
- flush has highest priority. State → IDLE and cnt → 0 next cycle. No ex_mc_done for the cancelled op. stall=0 during the flush cycle.
- stallreq_mem during BUSY: stall=011111. The FSM still counts, so MEM wait and the EX op overlap.
- stallreq_mem in DONE: stall=011111. ex_mc_done stays asserted and the FSM holds in DONE until stallreq_mem drops; EX must not lose its result.
- stall_cycles increments when stall[0]=1. It wraps modulo 2^CNT_W and is not cleared by flush.
- ex_mc_busy = (state==BUSY).

## Timing
- Reset values: state IDLE, cnt 0, ex_mc_busy 0, ex_mc_done 0, stall 000000, stall_cycles 0. rst applies at the clock edge; stall is forced 0 combinationally while rst=1.
- rst mid-operation aborts the FSM like flush. The performance counter also clears.
- stall has zero latency from its inputs (combinational); FSM outputs are registered state.
- Op started in cycle t with N≥1: stall=001111 in cycles t..t+N-1, ex_mc_done=1 in cycle t+N, EX advances at the end of t+N. The next ex_mc_start is accepted from cycle t+N+1.
- Back-to-back: a start in the cycle after DONE is accepted normally.

## Test plan
- Reset: assert rst 2 cycles with all requests high → stall=000000, ex_mc_busy=0, stall_cycles=0 after release.
- N=4 divide: ex_mc_start=1, ex_mc_cycles=4 at t=10 → stall=001111 at t=10..13, ex_mc_done=1 at t=14 only, stall=0 at t=14, stall_cycles=4.
- Edge lengths:
  - N=1 → one stall cycle, then done.
  - N=0 → no stall, no done.
  - N=63 → 63 stall cycles, then done.
- Priority: stallreq_id and stallreq_mem high during BUSY → stall=011111. Only stallreq_id high in IDLE → 000111.
- Flush mid-op: N=10 start at t=0, flush at t=5 → stall=0 at t=5, ex_mc_busy=0 from t=6, no ex_mc_done, next start accepted at t=6.
- MEM wait in DONE: stallreq_mem high for 3 cycles in the DONE cycle → ex_mc_done held for 4 cycles, then IDLE. Counter wrap: preload-equivalent run to 2^CNT_W-1 (small CNT_W build) → wraps to 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall merge, multi-cycle EX sequencer, stall-cycle counter
module pipe_stall_ctrl #(
    parameter int MC_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_mem,
    input  logic             ex_mc_start,
    input  logic [MC_W-1:0]  ex_mc_cycles,
    input  logic             flush,
    output logic [5:0]       stall,
    output logic             ex_mc_busy,
    output logic             ex_mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [MC_W-1:0] cnt;
    logic [MC_W-1:0] cnt_next;
    logic            ex_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The IDLE cycle that accepts the op is the first stall cycle, so BUSY only needs N-1 more.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_mc_start) begin
                        if (ex_mc_cycles >= MC_W'(2)) begin
                            state_next = S_BUSY;
                            cnt_next   = ex_mc_cycles - MC_W'(1);
                        end else if (ex_mc_cycles == MC_W'(1)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_next = cnt - MC_W'(1);
                    if (cnt == MC_W'(1)) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    // Hold the EX result while MEM is still waiting.
                    if (!stallreq_mem) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ex_mc_busy = (state == S_BUSY);
        ex_mc_done = (state == S_DONE);
        ex_req     = (state == S_BUSY) ||
                     ((state == S_IDLE) && ex_mc_start && (ex_mc_cycles != '0));
    end

    always_comb begin
        stall = 6'b000000;
        if (rst || flush) begin
            stall = 6'b000000;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (ex_req) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0]) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        flush;
    logic [5:0]  stall;
    logic        ex_mc_busy;
    logic        ex_mc_done;
    logic [31:0] stall_cycles;
    logic [5:0]  stall_s;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  stall_cycles_s;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_W(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush(flush),
        .stall(stall), .ex_mc_busy(ex_mc_busy), .ex_mc_done(ex_mc_done),
        .stall_cycles(stall_cycles)
    );

    pipe_stall_ctrl #(.MC_W(6), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush(flush),
        .stall(stall_s), .ex_mc_busy(busy_s), .ex_mc_done(done_s),
        .stall_cycles(stall_cycles_s)
    );

    // Apply one cycle of inputs just after the edge and return at mid-cycle for sampling.
    task automatic drive(input logic id, input logic mem, input logic start,
                         input logic [5:0] n, input logic fl);
        @(posedge clk);
        #1;
        stallreq_id  = id;
        stallreq_mem = mem;
        ex_mc_start  = start;
        ex_mc_cycles = n;
        flush        = fl;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
            n_tests++;
            if (stall !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_stall cyc%0d got %b want 000000", i, stall);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stallreq_id = 1'b0; stallreq_mem = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = 6'd0;
        @(negedge clk);
        n_tests++;
        if (stall !== 6'b000000 || ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got stall=%b busy=%b done=%b want 000000/0/0",
                     stall, ex_mc_busy, ex_mc_done);
        end
        n_tests++;
        if (stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counter got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_div4;
        drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
        for (int t = 0; t < 4; t++) begin
            if (t > 0) drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
            n_tests++;
            if (stall !== 6'b001111 || ex_mc_done !== 1'b0 || ex_mc_busy !== (t > 0)) begin
                n_fail++;
                $display("FAIL div4_t%0d got stall=%b done=%b busy=%b want 001111/0/%0d",
                         t, stall, ex_mc_done, ex_mc_busy, (t > 0));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1 || ex_mc_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div4_done got stall=%b done=%b busy=%b want 000000/1/0",
                     stall, ex_mc_done, ex_mc_busy);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 4;
        n_tests++;
        if (ex_mc_done !== 1'b0 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL div4_after got done=%b cnt=%0d want 0/%0d", ex_mc_done, stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_edge_lengths;
        int n_st;
        bit seen_done;
        drive(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        n_tests++;
        if (stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL n1_stall got %b want 001111", stall);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL n1_done got stall=%b done=%b want 000000/1", stall, ex_mc_done);
        end
        exp_cnt += 1;

        drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b000000 || ex_mc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL n0_start got stall=%b done=%b want 000000/0", stall, ex_mc_done);
        end
        for (int t = 0; t < 2; t++) begin
            drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
            n_tests++;
            if (ex_mc_done !== 1'b0 || ex_mc_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL n0_idle%0d got done=%b busy=%b want 0/0", t, ex_mc_done, ex_mc_busy);
            end
        end

        n_st = 0;
        seen_done = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 6'd63, 1'b0);
        if (stall === 6'b001111) n_st++;
        for (int t = 0; t < 100 && !seen_done; t++) begin
            drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
            if (ex_mc_done === 1'b1) seen_done = 1'b1;
            else if (stall === 6'b001111) n_st++;
        end
        n_tests++;
        if (!seen_done || n_st != 63) begin
            n_fail++;
            $display("FAIL n63 got done_seen=%0d stall_cycles_seen=%0d want 1/63", seen_done, n_st);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 63;
        n_tests++;
        if (ex_mc_done !== 1'b0 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL n63_after got done=%b cnt=%0d want 0/%0d", ex_mc_done, stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_priority;
        drive(1'b0, 1'b0, 1'b1, 6'd3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b011111 || ex_mc_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_mem_busy got stall=%b busy=%b want 011111/1", stall, ex_mc_busy);
        end
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL prio_ex_over_id got %b want 001111", stall);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (ex_mc_done !== 1'b1 || stall !== 6'b000000) begin
            n_fail++;
            $display("FAIL prio_done got done=%b stall=%b want 1/000000", ex_mc_done, stall);
        end
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall !== 6'b000111) begin
            n_fail++;
            $display("FAIL prio_id_idle got %b want 000111", stall);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 4;
        n_tests++;
        if (stall !== 6'b000000 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL prio_after got stall=%b cnt=%0d want 000000/%0d", stall, stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_flush;
        bit done_seen;
        done_seen = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
        for (int t = 1; t < 5; t++) drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
        n_tests++;
        if (stall !== 6'b000000) begin
            n_fail++;
            $display("FAIL flush_stall got %b want 000000", stall);
        end
        if (ex_mc_done === 1'b1) done_seen = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        n_tests++;
        if (ex_mc_busy !== 1'b0 || stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL flush_restart got busy=%b stall=%b want 0/001111", ex_mc_busy, stall);
        end
        if (ex_mc_done === 1'b1) done_seen = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        if (ex_mc_done === 1'b1) done_seen = 1'b1;
        n_tests++;
        if (done_seen || ex_mc_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_no_done got done_seen=%0d busy=%b want 0/1", done_seen, ex_mc_busy);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (ex_mc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_new_done got %b want 1", ex_mc_done);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 7;
        n_tests++;
        if (stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL flush_counter got %0d want %0d", stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_mem_in_done;
        drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, (t < 3), 1'b0, 6'd0, 1'b0);
            n_tests++;
            if (ex_mc_done !== 1'b1 || stall !== ((t < 3) ? 6'b011111 : 6'b000000)) begin
                n_fail++;
                $display("FAIL memdone_hold%0d got done=%b stall=%b want 1/%b", t, ex_mc_done, stall,
                         ((t < 3) ? 6'b011111 : 6'b000000));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 5;
        n_tests++;
        if (ex_mc_done !== 1'b0 || ex_mc_busy !== 1'b0 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL memdone_after got done=%b busy=%b cnt=%0d want 0/0/%0d",
                     ex_mc_done, ex_mc_busy, stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        n_tests++;
        if (ex_mc_busy !== 1'b1 || stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL b2b_busy got busy=%b stall=%b want 1/001111", ex_mc_busy, stall);
        end
        drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
        n_tests++;
        if (ex_mc_done !== 1'b1 || stall !== 6'b000000) begin
            n_fail++;
            $display("FAIL b2b_done_ignore got done=%b stall=%b want 1/000000", ex_mc_done, stall);
        end
        drive(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
        n_tests++;
        if (ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b0 || stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL b2b_restart got busy=%b done=%b stall=%b want 0/0/001111",
                     ex_mc_busy, ex_mc_done, stall);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (ex_mc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done got %b want 1", ex_mc_done);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt += 3;
        n_tests++;
        if (ex_mc_done !== 1'b0 || ex_mc_busy !== 1'b0 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL b2b_after got done=%b busy=%b cnt=%0d want 0/0/%0d",
                     ex_mc_done, ex_mc_busy, stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_wrap;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        n_tests++;
        if (stall_cycles !== 32'd0 || stall_cycles_s !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_reset got big=%0d small=%0d want 0/0", stall_cycles, stall_cycles_s);
        end
        for (int t = 0; t < 15; t++) drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt = 15;
        n_tests++;
        if (stall_cycles_s !== 4'd15 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL wrap_max got small=%0d big=%0d want 15/15", stall_cycles_s, stall_cycles);
        end
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        exp_cnt = 16;
        n_tests++;
        if (stall_cycles_s !== 4'd0 || stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL wrap_zero got small=%0d big=%0d want 0/16", stall_cycles_s, stall_cycles);
        end
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        n_tests++;
        if (stall_cycles !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL flush_keeps_counter got %0d want %0d", stall_cycles, exp_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        stallreq_id = 1'b1;
        stallreq_mem = 1'b1;
        ex_mc_start = 1'b1;
        ex_mc_cycles = 6'd5;
        flush = 1'b0;
        test_reset();
        test_div4();
        test_edge_lengths();
        test_priority();
        test_flush();
        test_mem_in_done();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
